// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, data/register-address types and the
// execute-stage entry layout used by the operand/writeback stage.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int REG_AW = 2;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef struct packed {
        logic      valid;
        logic [2:0] op;
        data_t     a;
        data_t     b;
        reg_addr_t rd;
    } ex_entry_t;

    localparam ex_entry_t EX_RESET = '{valid: 1'b0, op: 3'b000, a: 8'h00, b: 8'h00, rd: 2'b00};

    function automatic logic is_zero(input data_t v);
        return (v == {DATA_W{1'b0}});
    endfunction

endpackage

// File: rtl/regfile_4x8.sv
// Register file: two combinational operand read ports, one debug read port,
// one synchronous write port, asynchronous reset to RST_VAL.
module regfile_4x8
    import cpu_pkg::*;
#(
    parameter int                NREG    = 4,
    parameter logic [DATA_W-1:0] RST_VAL = 8'h00
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      we_i,
    input  reg_addr_t waddr_i,
    input  data_t     wdata_i,
    input  reg_addr_t raddr1_i,
    output data_t     rdata1_o,
    input  reg_addr_t raddr2_i,
    output data_t     rdata2_o,
    input  reg_addr_t dbg_addr_i,
    output data_t     dbg_data_o
);

    data_t mem_q [NREG];

    // Storage array: reset every entry, otherwise write one entry per edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= RST_VAL;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o   = mem_q[raddr1_i];
    assign rdata2_o   = mem_q[raddr2_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch / writeback stage around the 8-bit ALU. Define
// ALU_OPERAND_BYPASS_EN for the result bypass; otherwise a RAW interlock stalls.
module alu_operand_stage
    import cpu_pkg::*;
#(
    parameter int                NREG    = 4,
    parameter logic [DATA_W-1:0] RST_VAL = 8'h00
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  reg_addr_t   in_rd,
    input  reg_addr_t   in_rs1,
    input  reg_addr_t   in_rs2,
    input  logic        in_imm_sel,
    input  logic [7:0]  in_imm,
    input  logic        hold,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic [7:0]  alu_s,
    input  logic        alu_c,
    output logic        flag_c,
    output logic        flag_z,
    output logic        wb_valid,
    input  reg_addr_t   dbg_sel,
    output logic [7:0]  dbg_data
);

    ex_entry_t ex_q, ex_d;
    logic      flag_c_q, flag_c_d;
    logic      flag_z_q, flag_z_d;
    logic      retire_s;
    logic      transfer_s;
    logic      in_ready_s;
    data_t     rdata1_s, rdata2_s;
    data_t     op_a_s, op_b_s;

    regfile_4x8 #(
        .NREG    (NREG),
        .RST_VAL (RST_VAL)
    ) u_regfile (
        .clk_i      (CLK),
        .rst_n_i    (RST_N),
        .we_i       (retire_s),
        .waddr_i    (ex_q.rd),
        .wdata_i    (alu_s),
        .raddr1_i   (in_rs1),
        .rdata1_o   (rdata1_s),
        .raddr2_i   (in_rs2),
        .rdata2_o   (rdata2_s),
        .dbg_addr_i (dbg_sel),
        .dbg_data_o (dbg_data)
    );

    assign retire_s   = ex_q.valid & ~hold;
    assign transfer_s = in_valid & in_ready_s;

`ifdef ALU_OPERAND_BYPASS_EN
    // Operand resolution with forwarding of the result retiring at this edge.
    always_comb begin
        in_ready_s = ~hold;
        if (retire_s && (ex_q.rd == in_rs1)) begin
            op_a_s = alu_s;
        end else begin
            op_a_s = rdata1_s;
        end
        if (in_imm_sel) begin
            op_b_s = in_imm;
        end else if (retire_s && (ex_q.rd == in_rs2)) begin
            op_b_s = alu_s;
        end else begin
            op_b_s = rdata2_s;
        end
    end
`else
    logic raw_s;

    // Operands straight from the register file; a pending writer blocks its readers.
    always_comb begin
        raw_s      = ex_q.valid & ((ex_q.rd == in_rs1) | (~in_imm_sel & (ex_q.rd == in_rs2)));
        in_ready_s = ~hold & ~raw_s;
        op_a_s     = rdata1_s;
        if (in_imm_sel) begin
            op_b_s = in_imm;
        end else begin
            op_b_s = rdata2_s;
        end
    end
`endif

    // Next-state for the EX entry and the condition flags.
    always_comb begin
        ex_d     = ex_q;
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        if (!hold) begin
            if (transfer_s) begin
                ex_d = '{valid: 1'b1, op: in_op, a: op_a_s, b: op_b_s, rd: in_rd};
            end else begin
                ex_d.valid = 1'b0;
            end
        end else begin
            ex_d = ex_q;
        end
        if (retire_s) begin
            flag_c_d = alu_c;
            flag_z_d = is_zero(alu_s);
        end else begin
            flag_c_d = flag_c_q;
            flag_z_d = flag_z_q;
        end
    end

    // EX pipeline register and flag registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ex_q     <= EX_RESET;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            ex_q     <= ex_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
        end
    end

    assign in_ready = in_ready_s;
    assign alu_a    = ex_q.a;
    assign alu_b    = ex_q.b;
    assign alu_op   = ex_q.op;
    assign flag_c   = flag_c_q;
    assign flag_z   = flag_z_q;
    assign wb_valid = retire_s;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage with a behavioural 8-bit ALU.
module tb_alu_operand_stage;
    import cpu_pkg::*;

    logic       CLK, RST_N;
    logic       in_valid, in_ready;
    logic [2:0] in_op;
    logic [1:0] in_rd, in_rs1, in_rs2;
    logic       in_imm_sel;
    logic [7:0] in_imm;
    logic       hold;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_s;
    logic       alu_c;
    logic       flag_c, flag_z, wb_valid;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;

    int checks   = 0;
    int failures = 0;

`ifdef ALU_OPERAND_BYPASS_EN
    localparam int EXP_STALL = 0;
`else
    localparam int EXP_STALL = 1;
`endif

    alu_operand_stage dut (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm_sel(in_imm_sel), .in_imm(in_imm), .hold(hold),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_s(alu_s), .alu_c(alu_c),
        .flag_c(flag_c), .flag_z(flag_z), .wb_valid(wb_valid),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural ALU: carry is the 9th result bit for ADD/SUB, shifted-out bit for shifts.
    always_comb begin
        alu_c = 1'b0;
        alu_s = 8'h00;
        case (alu_op)
            OP_ADD:  {alu_c, alu_s} = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  {alu_c, alu_s} = {1'b0, alu_a} - {1'b0, alu_b};
            OP_AND:  alu_s = alu_a & alu_b;
            OP_OR:   alu_s = alu_a | alu_b;
            OP_XOR:  alu_s = alu_a ^ alu_b;
            OP_NOT:  alu_s = ~alu_a;
            OP_SHL:  {alu_c, alu_s} = {alu_a, 1'b0};
            OP_SHR:  begin alu_s = {1'b0, alu_a[7:1]}; alu_c = alu_a[0]; end
            default: alu_s = 8'h00;
        endcase
    end

    // Present an instruction (called just after a falling edge), wait for acceptance,
    // return at the falling edge after the accepting rising edge with in_valid still 1.
    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic sel, input logic [7:0] imm,
                         output int stalls);
        stalls     = 0;
        in_valid   = 1'b1;
        in_op      = op;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_imm_sel = sel;
        in_imm     = imm;
        #1;
        while (!in_ready && stalls < 8) begin
            @(negedge CLK); #1;
            stalls++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL issue_accept: in_ready=%b after %0d cycles, required 1", in_ready, stalls);
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        #1;
        checks++; if (alu_a !== 8'h00) begin failures++; $display("FAIL rst_alu_a: got %h exp 00", alu_a); end
        checks++; if (alu_b !== 8'h00) begin failures++; $display("FAIL rst_alu_b: got %h exp 00", alu_b); end
        checks++; if (alu_op !== 3'b000) begin failures++; $display("FAIL rst_alu_op: got %b exp 000", alu_op); end
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rst_wb_valid: got %b exp 0", wb_valid); end
        checks++; if ({flag_c, flag_z} !== 2'b00) begin failures++; $display("FAIL rst_flags: got %b exp 00", {flag_c, flag_z}); end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i); #1;
            checks++;
            if (dbg_data !== 8'h00) begin failures++; $display("FAIL rst_reg%0d: got %h exp 00", i, dbg_data); end
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_first_add();
        int st;
        issue(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, st);
        #1;
        checks++; if (alu_a !== 8'h00 || alu_b !== 8'h05 || alu_op !== OP_ADD) begin
            failures++; $display("FAIL add_ex: got a=%h b=%h op=%b exp a=00 b=05 op=000", alu_a, alu_b, alu_op); end
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL add_wb_valid: got %b exp 1", wb_valid); end
        in_valid = 1'b0;
        @(negedge CLK);
        dbg_sel = 2'd1; #1;
        checks++; if (dbg_data !== 8'h05) begin failures++; $display("FAIL add_r1: got %h exp 05", dbg_data); end
        checks++; if ({flag_c, flag_z} !== 2'b00) begin failures++; $display("FAIL add_flags: got cz=%b exp 00", {flag_c, flag_z}); end
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL add_wb_idle: got %b exp 0", wb_valid); end
    endtask

    task automatic test_back_to_back();
        int st;
        issue(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h07, st);
        issue(OP_SUB, 2'd2, 2'd1, 2'd1, 1'b0, 8'h00, st);
        checks++; if (st != EXP_STALL) begin failures++; $display("FAIL b2b_stalls: got %0d exp %0d", st, EXP_STALL); end
        #1;
        checks++; if (alu_a !== 8'h07 || alu_b !== 8'h07 || alu_op !== OP_SUB) begin
            failures++; $display("FAIL b2b_operands: got a=%h b=%h op=%b exp a=07 b=07 op=001", alu_a, alu_b, alu_op); end
        in_valid = 1'b0;
        @(negedge CLK);
        dbg_sel = 2'd2; #1;
        checks++; if (dbg_data !== 8'h00) begin failures++; $display("FAIL b2b_r2: got %h exp 00", dbg_data); end
        checks++; if ({flag_c, flag_z} !== 2'b01) begin failures++; $display("FAIL b2b_flags: got cz=%b exp 01", {flag_c, flag_z}); end
    endtask

    task automatic test_carry();
        int st;
        issue(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'hF0, st);
        issue(OP_ADD, 2'd3, 2'd1, 2'd0, 1'b1, 8'h20, st);
        in_valid = 1'b0;
        @(negedge CLK);
        dbg_sel = 2'd3; #1;
        checks++; if (dbg_data !== 8'h10) begin failures++; $display("FAIL carry_r3: got %h exp 10", dbg_data); end
        dbg_sel = 2'd1; #1;
        checks++; if (dbg_data !== 8'hF0) begin failures++; $display("FAIL carry_r1: got %h exp f0", dbg_data); end
        checks++; if ({flag_c, flag_z} !== 2'b10) begin failures++; $display("FAIL carry_flags: got cz=%b exp 10", {flag_c, flag_z}); end
    endtask

    task automatic test_hold();
        int st;
        int pulses;
        issue(OP_XOR, 2'd0, 2'd1, 2'd0, 1'b1, 8'h0F, st);
        in_valid = 1'b0;
        hold     = 1'b1;
        dbg_sel  = 2'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0 || wb_valid !== 1'b0) begin
                failures++; $display("FAIL hold_cycle%0d: got ready=%b wb=%b exp 0 0", i, in_ready, wb_valid); end
            @(negedge CLK);
            #1;
            checks++; if (dbg_data !== 8'h00 || {flag_c, flag_z} !== 2'b10 || alu_a !== 8'hF0) begin
                failures++; $display("FAIL hold_frozen%0d: got r0=%h cz=%b a=%h exp 00 10 f0", i, dbg_data, {flag_c, flag_z}, alu_a); end
        end
        hold   = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (wb_valid === 1'b1) pulses++;
            @(negedge CLK);
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL hold_pulses: got %0d exp 1", pulses); end
        #1;
        checks++; if (dbg_data !== 8'hFF) begin failures++; $display("FAIL hold_r0: got %h exp ff", dbg_data); end
        checks++; if ({flag_c, flag_z} !== 2'b00) begin failures++; $display("FAIL hold_flags: got cz=%b exp 00", {flag_c, flag_z}); end
    endtask

    task automatic test_debug();
        int st;
        dbg_sel = 2'd3;
        @(negedge CLK);
        issue(OP_ADD, 2'd3, 2'd2, 2'd0, 1'b1, 8'hA5, st);
        in_valid = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b1 || dbg_data !== 8'h10) begin
            failures++; $display("FAIL dbg_prewrite: got wb=%b data=%h exp 1 10", wb_valid, dbg_data); end
        @(negedge CLK);
        #1;
        checks++; if (dbg_data !== 8'hA5) begin failures++; $display("FAIL dbg_postwrite: got %h exp a5", dbg_data); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        in_valid   = 1'b1;
        in_op      = OP_XOR;
        in_rd      = 2'd2;
        in_rs1     = 2'd1;
        in_rs2     = 2'd0;
        in_imm_sel = 1'b1;
        in_imm     = 8'hFF;
        dbg_sel    = 2'd2;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready: got %b exp 1", in_ready); end
        @(posedge CLK);
        #1;
        RST_N    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b0 || alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== 3'b000) begin
            failures++; $display("FAIL rmid_ex: got wb=%b a=%h b=%h op=%b exp 0 00 00 000", wb_valid, alu_a, alu_b, alu_op); end
        pulses = 0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (wb_valid !== 1'b0) pulses++;
            @(negedge CLK);
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL rmid_wb: got %0d pulses exp 0", pulses); end
        #1;
        checks++; if (dbg_data !== 8'h00) begin failures++; $display("FAIL rmid_r2: got %h exp 00", dbg_data); end
        checks++; if ({flag_c, flag_z} !== 2'b00) begin failures++; $display("FAIL rmid_flags: got cz=%b exp 00", {flag_c, flag_z}); end
        dbg_sel = 2'd3; #1;
        checks++; if (dbg_data !== 8'h00) begin failures++; $display("FAIL rmid_r3: got %h exp 00", dbg_data); end
    endtask

    initial begin
        RST_N      = 1'b1;
        in_valid   = 1'b0;
        in_op      = 3'b000;
        in_rd      = 2'd0;
        in_rs1     = 2'd0;
        in_rs2     = 2'd0;
        in_imm_sel = 1'b0;
        in_imm     = 8'h00;
        hold       = 1'b0;
        dbg_sel    = 2'd0;
        #2;
        RST_N = 1'b0;
        test_reset();
        test_first_add();
        test_back_to_back();
        test_carry();
        test_hold();
        test_debug();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch / writeback stage wrapped around the 8-bit ALU.
- Holds a 4 x 8-bit register file and an execute (EX) pipeline register that drives the ALU `A`, `B` and `op` inputs.
- Captures the ALU `S` and carry result back into the destination register, together with the C and Z flags.
- Accepts one instruction per cycle from the decoder over a valid/ready handshake.

Parameters:
- `NREG`, 4, number of registers; register address width is `$clog2(NREG)`, which is 2 at the default.
- `RST_VAL`, 8'h00, reset value of every register-file entry.

Ports:
- `CLK`  in  1  clock; all state updates on its rising edge.
- `RST_N`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  decoder presents an instruction.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `in_op`  in  3  ALU opcode, passed through unchanged.
- `in_rd`  in  2  destination register.
- `in_rs1`  in  2  source register for `A`.
- `in_rs2`  in  2  source register for `B`.
- `in_imm_sel`  in  1  when 1, `B` is taken from `in_imm` instead of `in_rs2`.
- `in_imm`  in  8  immediate operand.
- `hold`  in  1  downstream stall; freezes the EX register.
- `alu_a`  out  8  to ALU `A`.
- `alu_b`  out  8  to ALU `B`.
- `alu_op`  out  3  to ALU `op`.
- `alu_s`  in  8  from ALU `S`.
- `alu_c`  in  1  from ALU `C_out`.
- `flag_c`  out  1  carry flag.
- `flag_z`  out  1  zero flag.
- `wb_valid`  out  1  pulses for the cycle in which an EX entry retires.
- `dbg_sel`  in  2  debug register select.
- `dbg_data`  out  8  combinational read of `reg[dbg_sel]`.

Behaviour:
- **Reset** (`RST_N` = 0, asynchronous):
  - All registers set to `RST_VAL`.
  - `ex_valid` = 0, `ex_op` = 0, `ex_a` = 0, `ex_b` = 0, `ex_rd` = 0.
  - `flag_c` = 0, `flag_z` = 0.
  - `alu_a`, `alu_b` and `alu_op` read 0; `wb_valid` = 0.
  - A reset mid-instruction discards the EX entry with no writeback.
- **EX register:**
  - `alu_a`, `alu_b` and `alu_op` are driven directly from the EX register.
  - The ALU is combinational, so `alu_s` and `alu_c` are valid in the same cycle.
- **Retire:**
  - `retire` = `ex_valid & ~hold`.
  - On a retire edge: `reg[ex_rd]` <= `alu_s`, `flag_c` <= `alu_c`, `flag_z` <= (`alu_s` == 0).
  - `wb_valid` = `retire` (combinational).
  - Flags are never updated on a non-retire cycle.
- **Handshake:**
  - `in_ready` = `~hold` (bypass build, see Optional Feature).
  - Transfer occurs when `in_valid & in_ready`.
  - On a transfer edge the EX register loads `in_op`, the resolved `A`/`B` and `in_rd`, and sets `ex_valid` = 1.
  - When `~hold` and there is no transfer, `ex_valid` <= 0 (bubble); the other EX fields are don't-care.
  - When `hold` = 1, the EX register is frozen and nothing retires.
- **Latency and throughput:**
  - Accept at edge N → ALU inputs valid during cycle N+1 → writeback at edge N+1 if not held.
  - Throughput is 1 instruction per cycle.
- **Operand resolution at accept:**
  - `A` = bypass(`in_rs1`).
  - `B` = `in_imm_sel` ? `in_imm` : bypass(`in_rs2`).
  - bypass(r) = (`retire` & `ex_rd` == r) ? `alu_s` : `reg[r]`.
  - This covers a back-to-back dependency, where the write and the read happen at the same edge.
- **Corner cases:**
  - `rd` equal to `rs1` or `rs2` in the same instruction is legal; it reads the old or bypassed value.
  - A debug read during a write returns the pre-write value.
  - No register is hard-wired to zero.
- **Width rule:** all data paths are 8 bits. `flag_c` stores `alu_c` verbatim; this stage applies no opcode-specific carry interpretation.

Optional Feature:
- Macro: `ALU_OPERAND_BYPASS_EN`.
- **Defined:** bypass exactly as described in Behaviour; `in_ready` = `~hold`.
- **Undefined:** no bypass mux, so operands are always read from `reg[]`.
  - A RAW interlock is added: `raw` = `ex_valid` & (`ex_rd` == `in_rs1` | (~`in_imm_sel` & `ex_rd` == `in_rs2`)).
  - `in_ready` = `~hold & ~raw`.
  - A dependent instruction therefore stalls exactly one cycle while the EX entry retires. The following cycle is a bubble or an accept, and the operand is read after writeback.

Decomposition:
- Shared package `cpu_pkg` holds:
  - the opcode constants `OP_ADD`=3'b000, `OP_SUB`=3'b001, `OP_AND`=3'b010, `OP_OR`=3'b011, `OP_XOR`=3'b100, `OP_NOT`=3'b101, `OP_SHL`=3'b110, `OP_SHR`=3'b111;
  - `DATA_W`=8;
  - the `reg_addr_t` typedef.
- One natural sub-module: `regfile_4x8`, with 2 combinational read ports, 1 debug read port, 1 synchronous write port, and asynchronous reset.

Test Plan:
1. **Reset values:** release reset, then issue ADD r1=r0+imm 8'h05 → `wb_valid` 1 cycle later, r1=8'h05, `flag_z`=0, `flag_c`=0.
2. **Back-to-back dependency:** r1=8'h05, then SUB r2=r1-r1 on the next cycle → r2=8'h00, `flag_z`=1; the bypass build shows no stall, the non-bypass build shows exactly one `in_ready`=0 cycle.
3. **Carry:** r1=8'hF0, then ADD r3=r1+imm 8'h20 → r3=8'h10, `flag_c`=1, `flag_z`=0.
4. **Hold:**
   - Assert `hold` for 3 cycles with an EX entry pending → no writeback, flags and registers unchanged, `in_ready`=0.
   - Deassert `hold` → a single writeback and a single `wb_valid` pulse.
5. **Reset mid-operation:** accept XOR r2=r1^imm 8'hFF, then assert `RST_N`=0 before the retire edge → r2=`RST_VAL`, flags 0, `wb_valid` never pulses.
6. **Debug port:** write r3=8'hA5 while `dbg_sel`=3 → `dbg_data` shows the old value that cycle and 8'hA5 the next.
